// File: rtl/mem_port_arbiter.sv
// Arbitrates a write and a read requester onto one memory command port with burst-limited fairness.
// Accept in cycle N issues the command in N+1; fifo_full_mem or MAX_OUTSTANDING reads in flight drop readies combinationally.
module mem_port_arbiter #(
    parameter int ADDRESS_WIDTH   = 25,
    parameter int MAX_BURST       = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     wr_req_valid,
    input  logic [ADDRESS_WIDTH-1:0] wr_req_address,
    input  logic [7:0]               wr_req_data,
    output logic                     wr_req_ready,

    input  logic                     rd_req_valid,
    input  logic [ADDRESS_WIDTH-1:0] rd_req_address,
    output logic                     rd_req_ready,
    output logic [7:0]               rd_data,
    output logic                     rd_data_valid,

    output logic [ADDRESS_WIDTH-1:0] address_mem,
    output logic                     wr_mem,
    output logic [7:0]               data_out_mem,
    output logic                     data_out_ready_mem,
    input  logic                     fifo_full_mem,
    input  logic [7:0]               data_in_mem,
    input  logic                     data_in_ready_mem,
    output logic                     rd_underflow_err
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
    localparam logic [BW-1:0] BURST_ONE = BW'(1);
    localparam logic [OW-1:0] OUT_MAX   = OW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, WR_OWN, RD_OWN} state_t;

    state_t         state;
    logic [BW-1:0]  burst_cnt;
    logic [OW-1:0]  outstanding;
    logic           wr_ok;
    logic           rd_ok;
    logic           burst_open;
    logic           grant_wr;
    logic           grant_rd;
    logic           ret_dec;

    always_comb begin
        wr_ok      = wr_req_valid && !fifo_full_mem;
        rd_ok      = rd_req_valid && !fifo_full_mem && (outstanding < OUT_MAX);
        burst_open = burst_cnt < BURST_MAX;
        grant_wr   = 1'b0;
        grant_rd   = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (rd_ok)      grant_rd = 1'b1;
                    else if (wr_ok) grant_wr = 1'b1;
                end
                // Owner keeps the port until its burst is spent, then yields only if the other side can go.
                WR_OWN: begin
                    if (wr_ok && burst_open) grant_wr = 1'b1;
                    else if (rd_ok)          grant_rd = 1'b1;
                    else if (wr_ok)          grant_wr = 1'b1;
                end
                RD_OWN: begin
                    if (rd_ok && burst_open) grant_rd = 1'b1;
                    else if (wr_ok)          grant_wr = 1'b1;
                    else if (rd_ok)          grant_rd = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign wr_req_ready = grant_wr;
    assign rd_req_ready = grant_rd;
    assign ret_dec      = data_in_ready_mem && (outstanding != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_rd) begin
                        state     <= RD_OWN;
                        burst_cnt <= BURST_ONE;
                    end else if (grant_wr) begin
                        state     <= WR_OWN;
                        burst_cnt <= BURST_ONE;
                    end
                end
                WR_OWN: begin
                    if (grant_wr) begin
                        if (burst_open) burst_cnt <= burst_cnt + BURST_ONE;
                    end else if (grant_rd) begin
                        state     <= RD_OWN;
                        burst_cnt <= BURST_ONE;
                    end else if (!wr_req_valid) begin
                        state     <= IDLE;
                        burst_cnt <= '0;
                    end
                end
                RD_OWN: begin
                    if (grant_rd) begin
                        if (burst_open) burst_cnt <= burst_cnt + BURST_ONE;
                    end else if (grant_wr) begin
                        state     <= WR_OWN;
                        burst_cnt <= BURST_ONE;
                    end else if (!rd_req_valid) begin
                        state     <= IDLE;
                        burst_cnt <= '0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    burst_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            address_mem        <= '0;
            wr_mem             <= 1'b0;
            data_out_mem       <= '0;
            data_out_ready_mem <= 1'b0;
        end else begin
            data_out_ready_mem <= grant_wr || grant_rd;
            if (grant_wr) begin
                address_mem  <= wr_req_address;
                wr_mem       <= 1'b1;
                data_out_mem <= wr_req_data;
            end else if (grant_rd) begin
                address_mem  <= rd_req_address;
                wr_mem       <= 1'b0;
            end
        end
    end

    // A return with nothing in flight is flagged but still forwarded; the count never goes below zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding      <= '0;
            rd_data          <= '0;
            rd_data_valid    <= 1'b0;
            rd_underflow_err <= 1'b0;
        end else begin
            rd_data_valid <= data_in_ready_mem;
            if (data_in_ready_mem) rd_data <= data_in_mem;
            if (data_in_ready_mem && (outstanding == '0)) rd_underflow_err <= 1'b1;
            case ({grant_rd, ret_dec})
                2'b10:   outstanding <= outstanding + OW'(1);
                2'b01:   outstanding <= outstanding - OW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: write stream, contention, backpressure, outstanding limit, reset.
module tb_mem_port_arbiter;

    localparam int AW = 25;
    localparam int BP_EXP [12] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 2};

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_req_valid;
    logic [AW-1:0] wr_req_address;
    logic [7:0]    wr_req_data;
    logic          wr_req_ready;
    logic          rd_req_valid;
    logic [AW-1:0] rd_req_address;
    logic          rd_req_ready;
    logic [7:0]    rd_data;
    logic          rd_data_valid;
    logic [AW-1:0] address_mem;
    logic          wr_mem;
    logic [7:0]    data_out_mem;
    logic          data_out_ready_mem;
    logic          fifo_full_mem;
    logic [7:0]    data_in_mem;
    logic          data_in_ready_mem;
    logic          rd_underflow_err;

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  auto_ret = 1'b0;

    mem_port_arbiter #(.ADDRESS_WIDTH(AW), .MAX_BURST(8), .MAX_OUTSTANDING(4)) dut (
        .clk                (clk),
        .reset              (reset),
        .wr_req_valid       (wr_req_valid),
        .wr_req_address     (wr_req_address),
        .wr_req_data        (wr_req_data),
        .wr_req_ready       (wr_req_ready),
        .rd_req_valid       (rd_req_valid),
        .rd_req_address     (rd_req_address),
        .rd_req_ready       (rd_req_ready),
        .rd_data            (rd_data),
        .rd_data_valid      (rd_data_valid),
        .address_mem        (address_mem),
        .wr_mem             (wr_mem),
        .data_out_mem       (data_out_mem),
        .data_out_ready_mem (data_out_ready_mem),
        .fifo_full_mem      (fifo_full_mem),
        .data_in_mem        (data_in_mem),
        .data_in_ready_mem  (data_in_ready_mem),
        .rd_underflow_err   (rd_underflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; memory model optionally answers every read command in the following cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_ret) begin
            data_in_ready_mem = data_out_ready_mem && !wr_mem;
            data_in_mem       = 8'hE5;
        end
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_addr"}, address_mem, 0);
        chk({tag, "_wrmem"}, wr_mem, 0);
        chk({tag, "_dout"}, data_out_mem, 0);
        chk({tag, "_cmd"}, data_out_ready_mem, 0);
        chk({tag, "_rdvld"}, rd_data_valid, 0);
    endtask

    initial begin
        int  n_acc;
        int  prev;
        bit  exp_r;

        reset = 1'b1; wr_req_valid = 1'b1; rd_req_valid = 1'b1;
        wr_req_address = '0; wr_req_data = '0; rd_req_address = '0;
        fifo_full_mem = 1'b0; data_in_mem = '0; data_in_ready_mem = 1'b0;
        tick();
        chk("rst_wr_rdy", wr_req_ready, 0);
        chk("rst_rd_rdy", rd_req_ready, 0);
        tick();
        wr_req_valid = 1'b0; rd_req_valid = 1'b0; reset = 1'b0;
        check_cleared("rst");
        chk("rst_rddata", rd_data, 0);
        chk("rst_err", rd_underflow_err, 0);

        // Write-only stream: 10 consecutive commands, each one cycle after its accept.
        wr_req_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            wr_req_address = AW'(32'h10 + k);
            wr_req_data    = 8'(8'hA0 + k);
            #1;
            chk("ws_wr_rdy", wr_req_ready, 1);
            chk("ws_rd_rdy", rd_req_ready, 0);
            tick();
            chk("ws_cmd", data_out_ready_mem, 1);
            chk("ws_wrmem", wr_mem, 1);
            chk("ws_addr", address_mem, 32'h10 + k);
            chk("ws_dout", data_out_mem, 32'hA0 + k);
        end
        wr_req_valid = 1'b0;
        tick();
        chk("ws_idle_cmd", data_out_ready_mem, 0);
        chk("ws_idle_addr", address_mem, 32'h19);
        chk("ws_idle_dout", data_out_mem, 32'hA9);
        chk("ws_idle_wrmem", wr_mem, 1);

        // Contention from IDLE: R x8, W x8, R x8.
        auto_ret = 1'b1;
        wr_req_valid = 1'b1; rd_req_valid = 1'b1;
        wr_req_address = AW'(32'h200); wr_req_data = 8'h11; rd_req_address = AW'(32'h300);
        for (int g = 0; g < 24; g++) begin
            exp_r = (g < 8) || (g >= 16);
            #1;
            chk("ct_rd_rdy", rd_req_ready, exp_r);
            chk("ct_wr_rdy", wr_req_ready, !exp_r);
            tick();
            chk("ct_cmd", data_out_ready_mem, 1);
            chk("ct_wrmem", wr_mem, !exp_r);
        end
        wr_req_valid = 1'b0; rd_req_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("ct_err", rd_underflow_err, 0);

        // Backpressure mid write burst with a read waiting: burst count must freeze while full.
        n_acc = 0;
        wr_req_valid = 1'b1;
        rd_req_address = AW'(32'h1234);
        for (int c = 0; c < 12; c++) begin
            fifo_full_mem  = (c >= 3) && (c <= 5);
            rd_req_valid   = (c >= 1);
            wr_req_address = AW'(32'h40 + n_acc);
            wr_req_data    = 8'(8'h60 + n_acc);
            #1;
            chk("bp_wr_rdy", wr_req_ready, BP_EXP[c] == 1);
            chk("bp_rd_rdy", rd_req_ready, BP_EXP[c] == 2);
            prev = BP_EXP[c];
            tick();
            if (prev == 1) begin
                chk("bp_cmd", data_out_ready_mem, 1);
                chk("bp_addr", address_mem, 32'h40 + n_acc);
                chk("bp_wrmem", wr_mem, 1);
                n_acc++;
            end else if (prev == 2) begin
                chk("bp_rd_cmd", data_out_ready_mem, 1);
                chk("bp_rd_wrmem", wr_mem, 0);
                chk("bp_rd_addr", address_mem, 32'h1234);
                chk("bp_rd_dout_hold", data_out_mem, 32'h67);
            end else begin
                chk("bp_nocmd", data_out_ready_mem, 0);
            end
        end
        chk("bp_wr_total", n_acc, 8);
        wr_req_valid = 1'b0; rd_req_valid = 1'b0; fifo_full_mem = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        auto_ret = 1'b0;
        data_in_ready_mem = 1'b0;

        // Outstanding limit: 4 reads accepted then ready drops.
        rd_req_valid = 1'b1;
        rd_req_address = AW'(32'h500);
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("ol_rd_rdy", rd_req_ready, i < 4);
            tick();
        end
        data_in_mem = 8'h5C; data_in_ready_mem = 1'b1;
        #1;
        chk("ol_full_rdy", rd_req_ready, 0);
        tick();
        data_in_ready_mem = 1'b0;
        chk("ol_rdvld", rd_data_valid, 1);
        chk("ol_rddata", rd_data, 32'h5C);
        #1;
        chk("ol_one_more", rd_req_ready, 1);
        tick();
        chk("ol_rdvld_off", rd_data_valid, 0);
        #1;
        chk("ol_full_again", rd_req_ready, 0);

        // Accept and return together leave the count unchanged: exactly one more slot afterwards.
        data_in_mem = 8'h3A; data_in_ready_mem = 1'b1;
        tick();
        chk("sim_rddata_a", rd_data, 32'h3A);
        data_in_mem = 8'h3B;
        #1;
        chk("sim_rdy", rd_req_ready, 1);
        tick();
        data_in_ready_mem = 1'b0;
        chk("sim_b2b_vld", rd_data_valid, 1);
        chk("sim_rddata_b", rd_data, 32'h3B);
        #1;
        chk("sim_slot", rd_req_ready, 1);
        tick();
        #1;
        chk("sim_full", rd_req_ready, 0);
        chk("sim_err", rd_underflow_err, 0);
        rd_req_valid = 1'b0;

        // Reset with two reads in flight; the later return must be flagged and forwarded.
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        rd_req_valid = 1'b1; rd_req_address = AW'(32'h700);
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("rr_rd_rdy", rd_req_ready, 1);
            tick();
        end
        wr_req_valid = 1'b1; reset = 1'b1;
        #1;
        chk("rr_rst_rd_rdy", rd_req_ready, 0);
        chk("rr_rst_wr_rdy", wr_req_ready, 0);
        tick();
        reset = 1'b0; rd_req_valid = 1'b0; wr_req_valid = 1'b0;
        check_cleared("rr");
        chk("rr_err0", rd_underflow_err, 0);
        data_in_mem = 8'h77; data_in_ready_mem = 1'b1;
        tick();
        data_in_ready_mem = 1'b0;
        chk("rr_err", rd_underflow_err, 1);
        chk("rr_rdvld", rd_data_valid, 1);
        chk("rr_rddata", rd_data, 32'h77);
        chk("rr_cmd", data_out_ready_mem, 0);
        chk("rr_addr", address_mem, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
